seven_segment_reader: RTL and testbench

//  Receiving end of the multiplexed two-digit 7-segment display bus (led_port + c).

---
 rtl/seven_segment_reader.sv | 162 ++++++++++++++++
 tb/tb_seven_segment_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: receiving end of a multiplexed two-digit 7-segment bus.
// It synchronises {c, led_port}, waits for each digit pattern to hold steady,
// decodes the pattern to a hex nibble and reassembles the 8-bit displayed value.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   led_port  segment pattern, bit0 = a ... bit6 = g, 1 = lit
//   c         digit select, 1 = left (high nibble), 0 = right (low nibble)
//   addr      last complete recovered value
//   valid     one-cycle pulse when addr is updated with a new pair
//   changed   one-cycle pulse alongside valid when addr differs from before
//   err       one-cycle pulse when a stable pattern is not a hex glyph
//   lost      level, set when no capture has happened for TIMEOUT cycles
module seven_segment_reader #(
    parameter int unsigned AW            = 8,
    parameter int unsigned DW            = 7,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] led_port,
    input  logic          c,
    output logic [AW-1:0] addr,
    output logic          valid,
    output logic          changed,
    output logic          err,
    output logic          lost
);

    localparam int unsigned SW = DW + 1;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        SEEK,
        HALF,
        FULL
    } state_t;

    state_t        state;
    logic [SW-1:0] meta;
    logic [SW-1:0] s;
    logic [SW-1:0] s_prev;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [3:0]    hi_nib;
    logic [3:0]    lo_nib;
    logic          got_hi;
    logic          got_lo;

    logic          capture_c;
    logic          dec_ok_c;
    logic [3:0]    dec_nib_c;
    logic [AW-1:0] pair_c;

    // Capture fires only on the step into saturation, so a held pattern captures once.
    assign capture_c = (s == s_prev) && (cnt == CW'(STABLE_CYCLES - 1));
    assign pair_c    = AW'({hi_nib, lo_nib});

    // Segment pattern to hex nibble; anything else (including blank) is illegal.
    always_comb begin
        dec_ok_c  = 1'b1;
        dec_nib_c = 4'h0;
        case (s[DW-1:0])
            DW'(7'h3F): dec_nib_c = 4'h0;
            DW'(7'h06): dec_nib_c = 4'h1;
            DW'(7'h5B): dec_nib_c = 4'h2;
            DW'(7'h4F): dec_nib_c = 4'h3;
            DW'(7'h66): dec_nib_c = 4'h4;
            DW'(7'h6D): dec_nib_c = 4'h5;
            DW'(7'h7D): dec_nib_c = 4'h6;
            DW'(7'h07): dec_nib_c = 4'h7;
            DW'(7'h7F): dec_nib_c = 4'h8;
            DW'(7'h6F): dec_nib_c = 4'h9;
            DW'(7'h77): dec_nib_c = 4'hA;
            DW'(7'h7C): dec_nib_c = 4'hB;
            DW'(7'h39): dec_nib_c = 4'hC;
            DW'(7'h5E): dec_nib_c = 4'hD;
            DW'(7'h79): dec_nib_c = 4'hE;
            DW'(7'h71): dec_nib_c = 4'hF;
            default:    dec_ok_c  = 1'b0;
        endcase
    end

    // Synchroniser, stability counter, timeout and digit-pairing FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SEEK;
            meta    <= '0;
            s       <= '0;
            s_prev  <= '0;
            cnt     <= '0;
            tmo     <= '0;
            hi_nib  <= 4'h0;
            lo_nib  <= 4'h0;
            got_hi  <= 1'b0;
            got_lo  <= 1'b0;
            addr    <= '0;
            valid   <= 1'b0;
            changed <= 1'b0;
            err     <= 1'b0;
            lost    <= 1'b1;
        end else begin
            meta    <= {c, led_port};
            s       <= meta;
            s_prev  <= s;
            valid   <= 1'b0;
            changed <= 1'b0;
            err     <= 1'b0;

            if (s != s_prev) begin
                cnt <= '0;
            end else if (cnt != CW'(STABLE_CYCLES)) begin
                cnt <= cnt + CW'(1);
            end

            if (capture_c) begin
                tmo <= '0;
            end else if (tmo != TW'(TIMEOUT - 1)) begin
                tmo <= tmo + TW'(1);
            end

            if (capture_c) begin
                if (!dec_ok_c) begin
                    err    <= 1'b1;
                    state  <= SEEK;
                    got_hi <= 1'b0;
                    got_lo <= 1'b0;
                end else begin
                    lost <= 1'b0;
                    if (s[DW]) begin
                        hi_nib <= dec_nib_c;
                        got_hi <= 1'b1;
                    end else begin
                        lo_nib <= dec_nib_c;
                        got_lo <= 1'b1;
                    end
                    case (state)
                        SEEK: state <= HALF;
                        // Same digit again just refreshes its nibble.
                        HALF: state <= (s[DW] ? got_hi : got_lo) ? HALF : FULL;
                        default: state <= state;
                    endcase
                end
            end else if (tmo == TW'(TIMEOUT - 1)) begin
                lost   <= 1'b1;
                state  <= SEEK;
                got_hi <= 1'b0;
                got_lo <= 1'b0;
            end else if (state == FULL) begin
                addr    <= pair_c;
                valid   <= 1'b1;
                changed <= (pair_c != addr);
                got_hi  <= 1'b0;
                got_lo  <= 1'b0;
                state   <= SEEK;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed testbench for seven_segment_reader: drives a two-digit multiplexed
// display (8 clocks per digit) and checks recovered values, pulses and timeout.
module tb_seven_segment_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] led_port;
    logic       c;
    logic [7:0] addr;
    logic       valid;
    logic       changed;
    logic       err;
    logic       lost;

    int errors = 0;
    int checks = 0;

    int valid_cnt   = 0;
    int changed_cnt = 0;
    int err_cnt     = 0;
    logic [7:0] last_addr = 8'h00;

    logic [6:0] seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] steps [15] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78,
                               8'h89, 8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hDE, 8'h0F};

    seven_segment_reader dut (
        .clk      (clk),
        .reset    (reset),
        .led_port (led_port),
        .c        (c),
        .addr     (addr),
        .valid    (valid),
        .changed  (changed),
        .err      (err),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts output pulses and remembers addr at each valid.
    always @(posedge clk) begin
        if (valid) begin
            valid_cnt <= valid_cnt + 1;
            last_addr <= addr;
        end
        if (changed) changed_cnt <= changed_cnt + 1;
        if (err)     err_cnt     <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic phase(input logic cv, input logic [6:0] pat);
        c        = cv;
        led_port = pat;
        repeat (8) @(negedge clk);
    endtask

    task automatic pairs(input logic [7:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            phase(1'b1, seg[v[7:4]]);
            phase(1'b0, seg[v[3:0]]);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0;
        int c0;
        int e0;

        // Reset state
        reset    = 1'b0;
        c        = 1'b1;
        led_port = seg[14];
        settle(3);
        check("rst_addr", 32'(addr), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_changed", 32'(changed), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_lost", 32'(lost), 32'h1);

        // 1: left E captured first, then overwritten by F; right 0 -> F0
        reset = 1'b1;
        phase(1'b1, seg[14]);
        pairs(8'hF0, 1);
        settle(3);
        check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t1_last_addr", 32'(last_addr), 32'hF0);
        check("t1_addr", 32'(addr), 32'hF0);
        check("t1_changed_cnt", 32'(changed_cnt), 32'd1);
        check("t1_lost", 32'(lost), 32'h0);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);

        // 2: same value repeated, no change pulses
        v0 = valid_cnt; c0 = changed_cnt;
        pairs(8'hF0, 4);
        settle(3);
        check("t2_valid_delta", 32'(valid_cnt - v0), 32'd4);
        check("t2_changed_delta", 32'(changed_cnt - c0), 32'd0);
        check("t2_addr", 32'(addr), 32'hF0);

        // 3: walk through values, each held for three pairs
        for (int i = 0; i < 15; i++) begin
            v0 = valid_cnt; c0 = changed_cnt;
            pairs(steps[i], 3);
            settle(3);
            check($sformatf("t3_valid_delta_%0h", steps[i]), 32'(valid_cnt - v0), 32'd3);
            check($sformatf("t3_changed_delta_%0h", steps[i]), 32'(changed_cnt - c0), 32'd1);
            check($sformatf("t3_last_addr_%0h", steps[i]), 32'(last_addr), 32'(steps[i]));
        end
        check("t3_err_cnt", 32'(err_cnt), 32'd0);

        // 4: pattern toggling faster than the stability window, then timeout
        v0 = valid_cnt; e0 = err_cnt;
        c = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            led_port = (i % 2 == 0) ? seg[0] : seg[1];
            settle(2);
        end
        check("t4_lost_early", 32'(lost), 32'h0);
        for (int i = 0; i < 100; i++) begin
            led_port = (i % 2 == 0) ? seg[0] : seg[1];
            settle(2);
        end
        check("t4_lost", 32'(lost), 32'h1);
        check("t4_valid_delta", 32'(valid_cnt - v0), 32'd0);
        check("t4_err_delta", 32'(err_cnt - e0), 32'd0);
        check("t4_addr", 32'(addr), 32'h0F);

        // 5: blank right digit after a left capture, then a good pair AB
        v0 = valid_cnt; e0 = err_cnt;
        phase(1'b1, seg[10]);
        check("t5_lost_cleared", 32'(lost), 32'h0);
        phase(1'b0, 7'h00);
        settle(3);
        check("t5_err_delta", 32'(err_cnt - e0), 32'd1);
        check("t5_valid_delta", 32'(valid_cnt - v0), 32'd0);
        check("t5_addr_held", 32'(addr), 32'h0F);
        pairs(8'hAB, 1);
        settle(3);
        check("t5_valid_after", 32'(valid_cnt - v0), 32'd1);
        check("t5_addr", 32'(addr), 32'hAB);
        check("t5_err_after", 32'(err_cnt - e0), 32'd1);

        // 6: reset in the middle of a pair, then a fresh pair 34
        phase(1'b1, seg[1]);
        c        = 1'b0;
        led_port = seg[2];
        settle(3);
        reset = 1'b0;
        #1;
        check("t6_rst_addr", 32'(addr), 32'h00);
        check("t6_rst_valid", 32'(valid), 32'h0);
        check("t6_rst_changed", 32'(changed), 32'h0);
        check("t6_rst_err", 32'(err), 32'h0);
        check("t6_rst_lost", 32'(lost), 32'h1);
        settle(2);
        reset = 1'b1;
        v0 = valid_cnt;
        pairs(8'h34, 1);
        settle(3);
        check("t6_valid_delta", 32'(valid_cnt - v0), 32'd1);
        check("t6_addr", 32'(addr), 32'h34);
        check("t6_last_addr", 32'(last_addr), 32'h34);
        check("t6_lost", 32'(lost), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
